pipeline_control: RTL and testbench
===================================

// Module: pipeline_control
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline; drives the stall[5:0] vector read by every
//  pipeline latch and PC register. Bit map: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
//  Resolves stage stall requests by priority and sequences exception redirects as a freeze-then-flush.
//  Counts stall cycles. Optionally runs a watchdog that breaks a stall stuck too long.
// PARAMETERS
//  WATCHDOG_LIMIT   1024          consecutive stalled cycles before a watchdog flush (watchdog build only)
//  WATCHDOG_VECTOR  32'hBFC00380  redirect PC on watchdog flush (watchdog build only)
// PORTS
//  clock                 in   1   single clock; all state changes on posedge
//  reset                 in   1   synchronous, active-high (`RESET_ENABLE); sampled on posedge clock
//  id_stall_request      in   1   ID hazard (load-use); holds pc/if/id
//  ex_stall_request      in   1   EX multi-cycle op busy; holds pc..ex
//  mem_stall_request     in   1   MEM bus wait; holds pc..mem
//  mem_exception_valid   in   1   MEM-stage instruction raises exception/eret this cycle
//  mem_exception_new_pc  in   32  redirect target for that exception
//  stall                 out  6   per-stage hold, 1 = `STALL_ENABLE
//  flush                 out  1   clear all pipeline latches this cycle
//  flush_pc              out  32  PC loaded while flush = 1
//  stall_cycle_count     out  32  cycles with stall[0] = 1 since reset
//  watchdog_timeout      out  1   sticky watchdog flag (0 when watchdog is compiled out)
// BEHAVIOUR
//  Reset: state = IDLE, stall = 0, flush = 0, flush_pc = 0, stall_cycle_count = 0, watchdog_timeout = 0.
//   While reset = 1, all outputs read reset values.
//  FSM: IDLE, FLUSH. stall and flush are combinational from state and inputs (0-cycle latency);
//   latches see them at the same posedge.
//  IDLE stall priority, first match wins:
//   - mem_stall_request -> 6'b011111. An exception is NOT accepted this cycle; it waits for the request to drop.
//   - mem_exception_valid -> 6'b111111 (full freeze). flush_pc <= mem_exception_new_pc; next state FLUSH.
//   - ex_stall_request -> 6'b001111.
//   - id_stall_request -> 6'b000111.
//   - otherwise 6'b000000.
//  FLUSH (exactly 1 cycle):
//   - flush = 1, stall = 6'b000000; all request/exception inputs ignored; next state IDLE.
//   - Redirect latency: exception seen in cycle N -> flush = 1 in cycle N+1 -> pc = flush_pc after edge N+1.
//  flush_pc holds its last value outside FLUSH. It changes only on an accepted exception or watchdog fire.
//  stall_cycle_count: +1 at every posedge where stall[0] = 1 (freeze cycle included). Wraps 2^32-1 -> 0.
//  Reset asserted in any state -> IDLE next edge. A pending redirect is discarded.
//  Back-to-back exception: FLUSH ignores inputs. An exception still valid in the first IDLE cycle is accepted again.
// CONFIGURATION
//  `PIPELINE_WATCHDOG_EN defined:
//   - Watchdog counter: in IDLE it counts consecutive cycles with stall[0] = 1.
//   - Counter clears on any cycle with stall[0] = 0, on FLUSH, and on reset.
//   - Counter width: $clog2(WATCHDOG_LIMIT+1); it saturates and never wraps.
//   - Fire: counter == WATCHDOG_LIMIT-1 and still stalled -> flush_pc <= WATCHDOG_VECTOR, next state FLUSH.
//     watchdog_timeout <= 1 and stays set until reset.
//   - An exception accepted in the same cycle wins: flush_pc = exception target, watchdog_timeout not set.
//  `PIPELINE_WATCHDOG_EN undefined: no counter, watchdog_timeout tied 0, stalls may last indefinitely.
// TESTING
//  Reset:
//   - Pulse reset 2 cycles, then idle inputs -> stall = 0, flush = 0, flush_pc = 0, count = 0.
//  Stall priority:
//   - id only -> 000111. id + ex -> 001111. id + ex + mem -> 011111.
//   - mem held 5 cycles -> count += 5.
//  Exception redirect:
//   - mem_exception_valid = 1, new_pc = 32'h00000020 in cycle N -> cycle N stall = 111111.
//   - Cycle N+1: flush = 1, flush_pc = 32'h00000020, stall = 0. Cycle N+2 in IDLE.
//  Exception under mem stall:
//   - exception + mem_stall for 3 cycles -> stall = 011111, no flush.
//   - mem_stall drops -> freeze cycle, then flush the following cycle.
//  Reset mid-sequence:
//   - Assert reset during the freeze cycle -> no flush afterwards, flush_pc = 0.
//  Watchdog (`PIPELINE_WATCHDOG_EN, WATCHDOG_LIMIT = 8):
//   - ex_stall held 8 cycles -> flush = 1 in cycle 9, flush_pc = 32'hBFC00380, timeout = 1.
//   - Timeout stays 1 until reset.

Source files
------------

// File: rtl/pipeline_control_if.sv
// Stall/flush control bundle between the pipeline stages and pipeline_control.
// master = the sequencer (drives stall/flush), slave = the pipeline stages (raise requests).
interface pipeline_control_if;
  logic        id_stall_request;
  logic        ex_stall_request;
  logic        mem_stall_request;
  logic        mem_exception_valid;
  logic [31:0] mem_exception_new_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] stall_cycle_count;
  logic        watchdog_timeout;

  modport master (
    input  id_stall_request,
    input  ex_stall_request,
    input  mem_stall_request,
    input  mem_exception_valid,
    input  mem_exception_new_pc,
    output stall,
    output flush,
    output flush_pc,
    output stall_cycle_count,
    output watchdog_timeout
  );

  modport slave (
    output id_stall_request,
    output ex_stall_request,
    output mem_stall_request,
    output mem_exception_valid,
    output mem_exception_new_pc,
    input  stall,
    input  flush,
    input  flush_pc,
    input  stall_cycle_count,
    input  watchdog_timeout
  );
endinterface

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline: priority stall resolution and freeze-then-flush redirects.
// Define PIPELINE_WATCHDOG_EN to build the stuck-stall watchdog (WATCHDOG_LIMIT / WATCHDOG_VECTOR).
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | resolve stall requests; accept exception (freeze) or watchdog
//  ST_FLUSH | one cycle: flush = 1, stall = 0, inputs ignored, redirect PC
module pipeline_control
`ifdef PIPELINE_WATCHDOG_EN
#(
  parameter int unsigned WATCHDOG_LIMIT  = 1024,
  parameter logic [31:0] WATCHDOG_VECTOR = 32'hBFC00380
)
`endif
(
  input  logic               clock,
  input  logic               reset,
  pipeline_control_if.master bus
);

  localparam logic [5:0] STALL_NONE   = 6'b000000;
  localparam logic [5:0] STALL_ID     = 6'b000111;
  localparam logic [5:0] STALL_EX     = 6'b001111;
  localparam logic [5:0] STALL_MEM    = 6'b011111;
  localparam logic [5:0] STALL_FREEZE = 6'b111111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  stall_d;
  logic        flush_d;
  logic        accept_exc;
  logic        wd_fire;
  logic [31:0] flush_pc_q;
  logic [31:0] stall_count_q;
  logic        timeout_q;

`ifdef PIPELINE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_LIMIT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

  logic [WD_W-1:0] wd_cnt_q;
`endif

  // Next state and the combinational stall/flush vector seen by the latches this cycle.
  always_comb begin
    state_d    = state_q;
    stall_d    = STALL_NONE;
    flush_d    = 1'b0;
    accept_exc = 1'b0;
    wd_fire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A pending exception waits out a MEM bus wait rather than freezing mid-access.
        if (bus.mem_stall_request) begin
          stall_d = STALL_MEM;
        end else if (bus.mem_exception_valid) begin
          stall_d    = STALL_FREEZE;
          accept_exc = 1'b1;
          state_d    = ST_FLUSH;
        end else if (bus.ex_stall_request) begin
          stall_d = STALL_EX;
        end else if (bus.id_stall_request) begin
          stall_d = STALL_ID;
        end

`ifdef PIPELINE_WATCHDOG_EN
        if (!accept_exc && stall_d[0] && (wd_cnt_q == WD_LAST)) begin
          wd_fire = 1'b1;
          state_d = ST_FLUSH;
        end
`endif
      end

      ST_FLUSH: begin
        flush_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset overrides everything, discarding any redirect in progress.
    if (reset) begin
      state_d    = ST_IDLE;
      stall_d    = STALL_NONE;
      flush_d    = 1'b0;
      accept_exc = 1'b0;
      wd_fire    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      flush_pc_q    <= 32'd0;
      stall_count_q <= 32'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept_exc) begin
        flush_pc_q <= bus.mem_exception_new_pc;
      end
`ifdef PIPELINE_WATCHDOG_EN
      else if (wd_fire) begin
        flush_pc_q <= WATCHDOG_VECTOR;
      end
`endif

      if (stall_d[0]) begin
        stall_count_q <= stall_count_q + 32'd1;
      end

      if (wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef PIPELINE_WATCHDOG_EN
  // Consecutive-stall counter; saturates so a huge LIMIT never wraps back to an early fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && stall_d[0] && !wd_fire) begin
      if (wd_cnt_q != WD_MAX) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
    end else begin
      wd_cnt_q <= '0;
    end
  end
`endif

  // Registered outputs read their reset values for the whole reset cycle, not just after the edge.
  assign bus.stall             = stall_d;
  assign bus.flush             = flush_d;
  assign bus.flush_pc          = reset ? 32'd0 : flush_pc_q;
  assign bus.stall_cycle_count = reset ? 32'd0 : stall_count_q;
  assign bus.watchdog_timeout  = reset ? 1'b0  : timeout_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: cycle-by-cycle vector table through a scoreboard queue.
// Define PIPELINE_WATCHDOG_EN on both RTL and bench to exercise the watchdog with WATCHDOG_LIMIT = 8.
module tb_pipeline_control;

  typedef struct {
    logic        rst;
    logic        id;
    logic        ex;
    logic        mem;
    logic        exc;
    logic [31:0] npc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_fpc;
    logic        exp_timeout;
    string       name;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_count = 32'd0;
  vec_t sb[$];
  vec_t tbl[$];

  pipeline_control_if pif ();

`ifdef PIPELINE_WATCHDOG_EN
  pipeline_control #(.WATCHDOG_LIMIT(8), .WATCHDOG_VECTOR(32'hBFC00380)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (pif)
  );
`else
  pipeline_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (pif)
  );
`endif

  always #5 clock = ~clock;

  function automatic vec_t mk(input string name, input logic rst, input logic id, input logic ex,
                              input logic mem, input logic exc, input logic [31:0] npc,
                              input logic [5:0] st, input logic fl, input logic [31:0] fpc,
                              input logic to);
    vec_t v;
    v.name = name; v.rst = rst; v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.npc = npc;
    v.exp_stall = st; v.exp_flush = fl; v.exp_fpc = fpc; v.exp_timeout = to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare mid-cycle.
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clock);
    #1;
    reset                    = v.rst;
    pif.id_stall_request     = v.id;
    pif.ex_stall_request     = v.ex;
    pif.mem_stall_request    = v.mem;
    pif.mem_exception_valid  = v.exc;
    pif.mem_exception_new_pc = v.npc;
    sb.push_back(v);
    @(negedge clock);
    e = sb.pop_front();
    if (e.rst) exp_count = 32'd0;
    check({e.name, ".stall"},   {26'd0, pif.stall},              {26'd0, e.exp_stall});
    check({e.name, ".flush"},   {31'd0, pif.flush},              {31'd0, e.exp_flush});
    check({e.name, ".flush_pc"}, pif.flush_pc,                   e.exp_fpc);
    check({e.name, ".count"},    pif.stall_cycle_count,          exp_count);
    check({e.name, ".timeout"}, {31'd0, pif.watchdog_timeout},   {31'd0, e.exp_timeout});
    if (!e.rst && e.exp_stall[0]) exp_count = exp_count + 32'd1;
  endtask

  initial begin
    pif.id_stall_request     = 1'b0;
    pif.ex_stall_request     = 1'b0;
    pif.mem_stall_request    = 1'b0;
    pif.mem_exception_valid  = 1'b0;
    pif.mem_exception_new_pc = 32'd0;

    //        name        rst id ex mem exc npc           stall      fl fpc            to
    tbl.push_back(mk("rst0",    1, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0));
    tbl.push_back(mk("rst1",    1, 0, 1, 0, 1, 32'h44,       6'b000000, 0, 32'h0,        0));
    tbl.push_back(mk("idle",    0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0));
    tbl.push_back(mk("id",      0, 1, 0, 0, 0, 32'h0,        6'b000111, 0, 32'h0,        0));
    tbl.push_back(mk("id_ex",   0, 1, 1, 0, 0, 32'h0,        6'b001111, 0, 32'h0,        0));
    tbl.push_back(mk("all3",    0, 1, 1, 1, 0, 32'h0,        6'b011111, 0, 32'h0,        0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("mem5",  0, 0, 0, 1, 0, 32'h0,        6'b011111, 0, 32'h0,        0));
    tbl.push_back(mk("exc_frz", 0, 0, 0, 0, 1, 32'h20,       6'b111111, 0, 32'h0,        0));
    tbl.push_back(mk("exc_fl",  0, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 32'h20,       0));
    tbl.push_back(mk("exc_idl", 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h20,       0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("exc_mem", 0, 0, 0, 1, 1, 32'h40,     6'b011111, 0, 32'h20,       0));
    tbl.push_back(mk("mem_drp", 0, 0, 0, 0, 1, 32'h40,       6'b111111, 0, 32'h20,       0));
    tbl.push_back(mk("fl_ign",  0, 1, 1, 1, 1, 32'h60,       6'b000000, 1, 32'h40,       0));
    tbl.push_back(mk("b2b_frz", 0, 0, 0, 0, 1, 32'h80,       6'b111111, 0, 32'h40,       0));
    tbl.push_back(mk("b2b_fl",  0, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 32'h80,       0));
    tbl.push_back(mk("b2b_idl", 0, 0, 1, 0, 0, 32'h0,        6'b001111, 0, 32'h80,       0));
    // Reset lands on the freeze cycle: redirect must be discarded.
    tbl.push_back(mk("rst_frz", 1, 0, 0, 0, 1, 32'h100,      6'b000000, 0, 32'h0,        0));
    tbl.push_back(mk("post_rs", 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0));
    tbl.push_back(mk("post_r2", 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0));

    foreach (tbl[i]) apply(tbl[i]);

    // Freeze visible, then reset during the flush cycle.
    apply(mk("frz2",    0, 0, 0, 0, 1, 32'h200, 6'b111111, 0, 32'h0, 0));
    apply(mk("rst_fl",  1, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0, 0));
    apply(mk("after",   0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0, 0));

`ifdef PIPELINE_WATCHDOG_EN
    for (int i = 0; i < 8; i++)
      apply(mk("wd_stl", 0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 0));
    apply(mk("wd_fl",   0, 0, 1, 0, 0, 32'h0, 6'b000000, 1, 32'hBFC00380, 1));
    for (int i = 0; i < 3; i++)
      apply(mk("wd_stk", 0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'hBFC00380, 1));
    apply(mk("wd_idl",  0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'hBFC00380, 1));
    // Exception arriving on the would-be fire cycle takes the redirect.
    for (int i = 0; i < 7; i++)
      apply(mk("wd_s2", 0, 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'hBFC00380, 1));
    apply(mk("wd_exc",  0, 1, 0, 0, 1, 32'h300, 6'b111111, 0, 32'hBFC00380, 1));
    apply(mk("wd_exfl", 0, 0, 0, 0, 0, 32'h0, 6'b000000, 1, 32'h300, 1));
    apply(mk("wd_rst",  1, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 0));
    apply(mk("wd_clr",  0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 0));
`else
    for (int i = 0; i < 20; i++)
      apply(mk("no_wd", 0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 0));
    apply(mk("no_wd_e", 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 0));
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
